// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table response checker.
package truth_table_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_CHG,
        ST_DONE
    } state_t;

    // Truth table of the two-input XOR project unit, indexed by {x,y}.
    localparam logic [3:0] XOR2_EXPECTED = 4'b0110;

endpackage

// File: rtl/truth_table_checker_stable_detect.sv
// Tracks the applied input code and pulses once it has held for SETTLE equal cycles.
module truth_table_checker_stable_detect
    import truth_table_checker_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         watch,
    input  logic         count_en,
    input  logic [N-1:0] x_in,
    output logic [N-1:0] last,
    output logic         changed,
    output logic         stable
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    logic [CW-1:0] settle_cnt;

    assign changed = (x_in != last);
    assign stable  = count_en && !changed && (settle_cnt == CNT_LAST);

    // Reload on start or on any code change; count equal cycles, saturating at the exit value.
    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= '0;
            settle_cnt <= '0;
        end else if (load) begin
            last       <= x_in;
            settle_cnt <= '0;
        end else if (watch && changed) begin
            last       <= x_in;
            settle_cnt <= '0;
        end else if (count_en && settle_cnt != CNT_LAST) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Records the unit-under-test output per settled input code and grades the finished table.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no run; waiting for start
// ST_SETTLE   | waiting for the current code to hold SETTLE cycles
// ST_SAMPLE   | capture z for code last, check for conflict
// ST_WAIT_CHG | code sampled; waiting for the next code to appear
// ST_DONE     | run finished (all codes seen or timed out); result held
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                N        = 2,
    parameter logic [2**N-1:0]   EXPECTED = XOR2_EXPECTED,
    parameter int                SETTLE   = 4,
    parameter int                TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      x_in,
    input  logic              z,
    output logic [2**N-1:0]   table_out,
    output logic [2**N-1:0]   seen,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              conflict,
    output logic              timeout
);

    localparam int D  = 2**N;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t         state, state_d;
    logic [D-1:0]   table_q, table_d;
    logic [D-1:0]   seen_q, seen_d;
    logic           conflict_q, conflict_d;
    logic           timeout_q, timeout_d;
    logic           pass_q, pass_d;
    logic [TW-1:0]  to_cnt, to_cnt_d;

    logic           load, watch, count_en, changed, stable;
    logic [N-1:0]   last;

    assign watch    = (state == ST_SETTLE) || (state == ST_WAIT_CHG);
    assign count_en = (state == ST_SETTLE) && !start;

    truth_table_checker_stable_detect #(
        .N      (N),
        .SETTLE (SETTLE)
    ) u_stable_detect (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .watch    (watch),
        .count_en (count_en),
        .x_in     (x_in),
        .last     (last),
        .changed  (changed),
        .stable   (stable)
    );

    // Register FSM state and the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            table_q    <= '0;
            seen_q     <= '0;
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state      <= state_d;
            table_q    <= table_d;
            seen_q     <= seen_d;
            conflict_q <= conflict_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            to_cnt     <= to_cnt_d;
        end
    end

    // Next-state, capture and grading logic; timeout takes priority over a same-cycle code event.
    always_comb begin
        state_d    = state;
        table_d    = table_q;
        seen_d     = seen_q;
        conflict_d = conflict_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        to_cnt_d   = to_cnt;
        load       = 1'b0;

        if (start) begin
            table_d    = '0;
            seen_d     = '0;
            conflict_d = 1'b0;
            timeout_d  = 1'b0;
            pass_d     = 1'b0;
            to_cnt_d   = '0;
            load       = 1'b1;
            state_d    = ST_SETTLE;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (to_cnt == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        to_cnt_d = to_cnt + 1'b1;
                        if (stable) state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    to_cnt_d = '0;
                    if (seen_q[last] && (table_q[last] != z)) begin
                        conflict_d = 1'b1;
                    end else begin
                        table_d[last] = z;
                        seen_d[last]  = 1'b1;
                    end
                    state_d = (&seen_d) ? ST_DONE : ST_WAIT_CHG;
                end
                ST_WAIT_CHG: begin
                    if (to_cnt == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        to_cnt_d = to_cnt + 1'b1;
                        if (changed) state_d = ST_SETTLE;
                    end
                end
                default: ;
            endcase

            // Grade once, on the transition into DONE, so pass is valid with done.
            if (state_d == ST_DONE && state != ST_DONE) begin
                pass_d = (table_d == EXPECTED) && (&seen_d) && !conflict_d && !timeout_d;
            end
        end
    end

    assign table_out = table_q;
    assign seen      = seen_q;
    assign conflict  = conflict_q;
    assign timeout   = timeout_q;
    assign pass      = pass_q;
    assign done      = (state == ST_DONE);
    assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_WAIT_CHG);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: XOR/AND sweeps, glitch, conflict, stall, reset.
module tb_truth_table_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] x_in;
    logic       z;
    logic [3:0] table_out;
    logic [3:0] seen;
    logic       busy, done, pass, conflict, timeout;

    logic       mode_and;
    logic       flip;
    int         checks;
    int         failures;

    truth_table_checker #(
        .N        (2),
        .EXPECTED (4'b0110),
        .SETTLE   (4),
        .TIMEOUT  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .z         (z),
        .table_out (table_out),
        .seen      (seen),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .conflict  (conflict),
        .timeout   (timeout)
    );

    // Behavioural unit under test: XOR or AND of {x,y}, optionally inverted.
    assign z = (mode_and ? (x_in[1] & x_in[0]) : (x_in[1] ^ x_in[0])) ^ flip;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        x_in     = 2'd0;
        mode_and = 1'b0;
        flip     = 1'b0;

        // Reset state
        tick(3);
        chk("rst_table",    table_out,     4'b0000);
        chk("rst_seen",     seen,          4'b0000);
        chk("rst_busy",     4'(busy),      4'd0);
        chk("rst_done",     4'(done),      4'd0);
        chk("rst_pass",     4'(pass),      4'd0);
        chk("rst_conflict", 4'(conflict),  4'd0);
        chk("rst_timeout",  4'(timeout),   4'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_busy", 4'(busy), 4'd0);

        // XOR sweep, each code held 10 cycles
        x_in = 2'd0;
        pulse_start();
        chk("xor_busy", 4'(busy), 4'd1);
        tick(9);
        chk("xor_seen0", seen, 4'b0001);
        x_in = 2'd1; tick(10);
        x_in = 2'd2; tick(10);
        x_in = 2'd3; tick(10);
        chk("xor_table",    table_out,    4'b0110);
        chk("xor_seen",     seen,         4'b1111);
        chk("xor_done",     4'(done),     4'd1);
        chk("xor_busy_end", 4'(busy),     4'd0);
        chk("xor_pass",     4'(pass),     4'd1);
        chk("xor_conflict", 4'(conflict), 4'd0);
        chk("xor_timeout",  4'(timeout),  4'd0);

        // Wrong unit (AND); start issued from DONE clears everything next cycle
        mode_and = 1'b1;
        x_in = 2'd0;
        pulse_start();
        chk("restart_table", table_out, 4'b0000);
        chk("restart_seen",  seen,      4'b0000);
        chk("restart_done",  4'(done),  4'd0);
        chk("restart_pass",  4'(pass),  4'd0);
        chk("restart_busy",  4'(busy),  4'd1);
        tick(9);
        x_in = 2'd1; tick(10);
        x_in = 2'd2; tick(10);
        x_in = 2'd3; tick(10);
        chk("and_table", table_out, 4'b1000);
        chk("and_done",  4'(done),  4'd1);
        chk("and_pass",  4'(pass),  4'd0);

        // Glitch: code 2 for 3 cycles, then code 1; sample lands SETTLE+1 cycles later
        mode_and = 1'b0;
        x_in = 2'd2;
        pulse_start();
        tick(2);
        x_in = 2'd1;
        tick(5);
        chk("glitch_seen_early", seen, 4'b0000);
        tick(1);
        chk("glitch_seen",  seen,      4'b0010);
        chk("glitch_table", table_out, 4'b0010);
        tick(4);
        chk("glitch_busy", 4'(busy), 4'd1);
        chk("glitch_done", 4'(done), 4'd0);

        // Conflict: revisit code 1 with z inverted, then finish the sweep
        x_in = 2'd0; tick(10);
        chk("conf_seen01", seen, 4'b0011);
        flip = 1'b1;
        x_in = 2'd1; tick(10);
        chk("conf_flag",  4'(conflict), 4'd1);
        chk("conf_keep",  table_out,    4'b0010);
        flip = 1'b0;
        x_in = 2'd2; tick(10);
        x_in = 2'd3; tick(10);
        chk("conf_done",     4'(done),     4'd1);
        chk("conf_pass",     4'(pass),     4'd0);
        chk("conf_table",    table_out,    4'b0110);
        chk("conf_seen",     seen,         4'b1111);
        chk("conf_sticky",   4'(conflict), 4'd1);
        chk("conf_timeout",  4'(timeout),  4'd0);

        // Stall: only codes 0 and 1, then hold; timeout 64 cycles after the last sample
        x_in = 2'd0;
        pulse_start();
        tick(9);
        x_in = 2'd1;
        tick(5);
        chk("stall_seen_pre", seen, 4'b0001);
        tick(1);
        chk("stall_seen", seen, 4'b0011);
        tick(63);
        chk("stall_done_early",    4'(done),    4'd0);
        chk("stall_timeout_early", 4'(timeout), 4'd0);
        tick(1);
        chk("stall_done",    4'(done),    4'd1);
        chk("stall_timeout", 4'(timeout), 4'd1);
        chk("stall_pass",    4'(pass),    4'd0);
        chk("stall_seen_end", seen,       4'b0011);
        chk("stall_busy",    4'(busy),    4'd0);

        // Reset mid-run, with start asserted in the same cycle
        x_in = 2'd2;
        pulse_start();
        tick(7);
        chk("mid_seen", seen, 4'b0100);
        rst   = 1'b1;
        start = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b0;
        chk("mid_rst_table", table_out,    4'b0000);
        chk("mid_rst_seen",  seen,         4'b0000);
        chk("mid_rst_busy",  4'(busy),     4'd0);
        chk("mid_rst_done",  4'(done),     4'd0);
        chk("mid_rst_pass",  4'(pass),     4'd0);
        tick(6);
        chk("mid_rst_idle",  4'(busy),     4'd0);
        chk("mid_rst_seen2", seen,         4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable response checker: the receiving end of the exhaustive {x,y} stimulus sweep applied to a combinational unit under test.
- Watches the applied input vector and the unit's output z, waits for the inputs to settle, records z per input code into a truth table, and flags conflicts.
- When every code has been seen, compares the table against an expected truth table and reports pass/fail.
- Sits beside the unit under test on the board, so a sweep can be checked without a simulator.

Parameters:
- N, 2, width of the input vector (number of unit inputs); table depth is 2**N.
- EXPECTED, 4'b0110, expected truth table, 2**N bits; bit i is the expected z for input code i.
- SETTLE, 4, consecutive cycles the input code must hold before z is sampled; at least 1.
- TIMEOUT, 1024, maximum cycles without a new sample before the run aborts; at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new run from any state.
- x_in  in  N  input code currently applied to the unit, e.g. {x,y} with x as the MSB.
- z  in  1  unit output.
- table_out  out  2**N  captured truth table; bit i is the z captured for code i.
- seen  out  2**N  bit i set once code i has been sampled.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE; held until start or rst.
- pass  out  1  valid only when done=1.
- conflict  out  1  sticky: one code produced two different z values.
- timeout  out  1  sticky: run aborted by the timeout counter.

Behaviour:
- Reset: state=IDLE, all counters zero, every output 0. Reset mid-run abandons the run with no partial result kept.
- States are IDLE, SETTLE, SAMPLE, WAIT_CHG, DONE.
- A start pulse in any state:
  - clears table_out, seen, conflict, timeout and the timeout counter;
  - sets settle_cnt=0;
  - latches last=x_in;
  - goes to SETTLE.
- start and rst in the same cycle: rst wins.
- SETTLE:
  - If x_in != last: last<=x_in, settle_cnt<=0.
  - Otherwise settle_cnt increments; when settle_cnt==SETTLE-1, go to SAMPLE.
  - Minimum latency from a stable code to its sample: SETTLE+1 cycles.
- SAMPLE (one cycle, using the registered last as the code):
  - If seen[last]=1 and table_out[last]!=z, set conflict. table_out is not overwritten; the first capture is kept.
  - Else table_out[last]<=z and seen[last]<=1.
  - Timeout counter cleared.
  - Next state is DONE if seen is all-ones after the update, else WAIT_CHG.
- WAIT_CHG:
  - Stay until x_in != last, then last<=x_in, settle_cnt<=0, go to SETTLE.
  - Re-applying an already-seen code is legal and is sampled again for conflict checking.
- Timeout:
  - A counter runs in SETTLE and WAIT_CHG and clears on every SAMPLE.
  - When it reaches TIMEOUT-1: timeout<=1, go to DONE.
- DONE:
  - done=1, busy=0.
  - pass = (table_out==EXPECTED) && all seen && !conflict && !timeout.
  - pass and done are registered, valid in the cycle DONE is entered, and held.
- busy=1 in SETTLE, SAMPLE and WAIT_CHG.
- Width and wrap rules: settle_cnt is clog2(SETTLE+1) bits and the timeout counter is clog2(TIMEOUT) bits; neither can wrap, because both saturate at their exit condition. x_in is used unsigned as the table index.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SETTLE, SAMPLE, WAIT_CHG, DONE);
  - the default EXPECTED constant for the two-input XOR project unit.
- One natural sub-module: stable_detect, containing last, settle_cnt, and a one-cycle stable pulse that fires after SETTLE equal cycles, with a clear input. The checker FSM consumes that pulse.

Test Plan:
- XOR sweep: N=2, SETTLE=4, EXPECTED=4'b0110. Apply codes 0,1,2,3, each held 10 cycles, with z=x^y -> table_out=4'b0110, seen=4'b1111, done=1, pass=1, conflict=0, timeout=0.
- Wrong unit: same sweep with z=x&y -> table_out=4'b1000, done=1, pass=0.
- Glitchy inputs: code 2 held 3 cycles, then code 1 held 10 cycles -> code 2 is not sampled, seen=4'b0010 after the code-1 sample, and the sample occurs exactly SETTLE+1 cycles after code 1 first appears.
- Conflict: revisit code 1 with z flipped before completing the sweep -> conflict=1, table_out[1] keeps its first value, and at DONE pass=0.
- Stall: TIMEOUT=64, apply only codes 0 and 1, then hold -> timeout=1 and done=1 64 cycles after the last sample, pass=0, seen=4'b0011.
- Reset and restart: assert rst mid-run -> all outputs 0, state IDLE. Then a start pulse during DONE of a prior run -> flags and table clear the next cycle, busy=1.
